// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART frame receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_READY
  } state_e;

  localparam logic [7:0] SYNC_DEF = 8'hA5;

  // Counters stick at 255 rather than wrapping back to a misleading small value.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: one write port, one registered read port (read-before-write).
module uart_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [MAX_LEN];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Addresses past MAX_LEN (non power-of-two depth) read as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        rd_data_q <= '0;
    else if (int'(rd_addr_i) < MAX_LEN) rd_data_q <= mem_q[rd_addr_i];
    else                                 rd_data_q <= '0;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_rx_framer.sv
// Frame hunter/assembler behind the byte UART: sync, length, payload, XOR check,
// host handoff, receiver error supervision and saturating error/drop counters.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] SYNC        = SYNC_DEF,
  parameter int         TIMEOUT_CYC = 1024,
  parameter int         AW          = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    rx_dat,
  input  logic          rx_receiv,
  input  logic          rx_error,
  output logic          rx_clr,
  output logic          frame_valid,
  output logic [7:0]    frame_len,
  input  logic          frame_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [7:0]    bad_cnt,
  output logic [7:0]    drop_cnt
);

  localparam int         TW   = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] MAXL = 8'(MAX_LEN);

  state_e        state_q, state_d;
  logic [7:0]    len_q, len_d, chk_q, chk_d, idx_q, idx_d;
  logic [7:0]    bad_q, bad_d, drop_q, drop_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_prev_q, rx_clr_q;
  logic          err_rise, byte_v, active, tmo, wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_HUNT;
      len_q      <= '0;
      chk_q      <= '0;
      idx_q      <= '0;
      bad_q      <= '0;
      drop_q     <= '0;
      tmr_q      <= '0;
      err_prev_q <= 1'b0;
      rx_clr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      chk_q      <= chk_d;
      idx_q      <= idx_d;
      bad_q      <= bad_d;
      drop_q     <= drop_d;
      tmr_q      <= tmr_d;
      err_prev_q <= rx_error;
      rx_clr_q   <= err_rise;
    end
  end

  always_comb begin
    // An rx_error edge swallows any byte strobed in the same cycle.
    err_rise = rx_error & ~err_prev_q;
    byte_v   = rx_receiv & ~err_rise;
    active   = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
    tmo      = active && !byte_v && (tmr_q == TMAX);
    tmr_d    = (active && !byte_v) ? tmr_q + 1'b1 : '0;
    state_d  = state_q;
    len_d    = len_q;
    chk_d    = chk_q;
    idx_d    = idx_q;
    bad_d    = bad_q;
    drop_d   = drop_q;
    wr_en    = 1'b0;

    case (state_q)
      ST_HUNT: if (byte_v && rx_dat == SYNC) state_d = ST_LEN;
      ST_LEN: if (byte_v) begin
        if (rx_dat == 8'd0 || rx_dat > MAXL) begin
          bad_d   = sat_inc(bad_q);
          state_d = ST_HUNT;
        end else begin
          len_d   = rx_dat;
          chk_d   = rx_dat;
          idx_d   = '0;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: if (byte_v) begin
        wr_en = 1'b1;
        chk_d = chk_q ^ rx_dat;
        idx_d = idx_q + 8'd1;
        if (idx_q + 8'd1 == len_q) state_d = ST_CHECK;
      end
      ST_CHECK: if (byte_v) begin
        if (rx_dat == chk_q) state_d = ST_READY;
        else begin
          bad_d   = sat_inc(bad_q);
          state_d = ST_HUNT;
        end
      end
      ST_READY: begin
        if (byte_v)    drop_d  = sat_inc(drop_q);
        if (frame_ack) state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase

    // Receiver error and inter-byte timeout both abandon an in-flight frame.
    if (active && (err_rise || tmo)) begin
      state_d = ST_HUNT;
      bad_d   = sat_inc(bad_q);
      tmr_d   = '0;
    end
  end

  uart_frame_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (idx_q[AW-1:0]),
    .wr_data_i (rx_dat),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign rx_clr      = rx_clr_q;
  assign frame_valid = (state_q == ST_READY);
  assign frame_len   = len_q;
  assign bad_cnt     = bad_q;
  assign drop_cnt    = drop_q;

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Frame-level receive controller that sits directly behind the byte-level UART receiver. Consumes received bytes and receive/error status and hunts for sync. Assembles length-prefixed, XOR-checked frames into an internal buffer and presents each good frame to the host through a read port with valid/ack handshake. Also supervises the receiver: clears its sticky framing error, aborts stalled frames on timeout, and keeps saturating error/drop counters.

## Interface
Parameters:
- MAX_LEN, 16: maximum payload bytes per frame (1..255).
- SYNC, 8'hA5: frame start byte.
- TIMEOUT_CYC, 1024: inter-byte timeout in clk cycles within a frame (≥2).
- AW, $clog2(MAX_LEN): buffer address width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_dat  in  8  byte from receiver, valid when rx_receiv=1.
- rx_receiv  in  1  one-cycle byte-received strobe.
- rx_error  in  1  receiver sticky stop-bit error flag.
- rx_clr  out  1  one-cycle active-high synchronous clear to receiver.
- frame_valid  out  1  complete good frame held in buffer.
- frame_len  out  8  payload length of held frame.
- frame_ack  in  1  host releases held frame.
- rd_addr  in  AW  payload byte index.
- rd_data  out  8  buffer[rd_addr], registered.
- bad_cnt  out  8  bad frames (length, checksum, timeout, rx error), saturating.
- drop_cnt  out  8  bytes discarded while a frame is held, saturating.

## Operation
- States: HUNT, LEN, PAYLOAD, CHECK, READY.
- Byte accepted = cycle with rx_receiv=1.
- HUNT: byte==SYNC -> LEN; any other byte ignored, no count.
- LEN: len 0 or >MAX_LEN -> bad_cnt++, HUNT. Else store len, chk<=len, idx<=0 -> PAYLOAD.
- PAYLOAD: buffer[idx]<=byte, chk^=byte, idx++; after len-th byte -> CHECK.
- CHECK: byte==chk -> READY, frame_valid=1. Else bad_cnt++, HUNT.
- READY: all bytes dropped, drop_cnt++ each. frame_ack -> HUNT, frame_valid=0. A byte in the ack cycle is dropped and counted.
- Timeout: counter clears on every accepted byte and on entry to LEN. In LEN/PAYLOAD/CHECK, reaching TIMEOUT_CYC-1 with no byte -> bad_cnt++, HUNT. A byte in the expiry cycle wins.
- rx_error rising edge (registered prev vs current): rx_clr=1 next cycle.
  - If in LEN/PAYLOAD/CHECK: abort to HUNT, bad_cnt++.
  - In HUNT/READY: no state change, no count.
  - Takes precedence over a same-cycle rx_receiv, whose byte is discarded.
- Counters saturate at 255; no wrap.
- frame_ack outside READY is ignored.
- chk and idx are 8-bit; buffer is not cleared between frames.

## Timing
- Reset values: rx_clr=0, frame_valid=0, frame_len=0, rd_data=0, bad_cnt=0, drop_cnt=0, state HUNT, counters 0.
- Reset mid-frame discards the partial frame immediately (asynchronous).
- Check byte accepted at cycle T -> frame_valid and frame_len valid at T+1.
- frame_ack at cycle A -> frame_valid=0 at A+1; a SYNC byte at A+1 is accepted.
- rd_data = buffer[rd_addr] one cycle after rd_addr is presented.
- Write and read of the same address in the same cycle returns the old data. This cannot occur in READY.
- rx_error rises at cycle E -> rx_clr high for exactly cycle E+1. There is no second pulse while rx_error stays high; a re-arm requires rx_error low first.
- Counter increments are visible the cycle after the event.

## Structure
- Shared package uart_pkg holds:
  - state enum;
  - SYNC default;
  - saturating-increment function used by both counters.
- One sub-module, uart_frame_buf: MAX_LEN×8 single-write, single-registered-read RAM.
- The control FSM, timeout counter, checksum and error-edge logic stay in uart_rx_framer.

## Test plan
- Good frame: bytes A5 03 11 22 33 03 -> frame_valid=1 one cycle after last byte; frame_len=3; rd_addr=1 gives rd_data=22 next cycle; bad_cnt=0.
- Bad checksum: A5 02 10 20 31 -> no frame_valid, bad_cnt=1, back in HUNT. A following good frame A5 01 7E 7F is accepted.
- Bad length: A5 00 and A5 11 (with MAX_LEN=16) -> bad_cnt=2, no frame_valid.
- Timeout: A5 04 01, then idle TIMEOUT_CYC cycles -> bad_cnt=1, HUNT. A fresh good frame is then accepted.
- rx_error rises mid-PAYLOAD with a simultaneous rx_receiv -> rx_clr single pulse next cycle, byte discarded, bad_cnt=1, HUNT.
- Overrun: hold a good frame without ack and send 3 bytes -> drop_cnt=3, buffer contents unchanged. Ack -> frame_valid low next cycle.
